pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_adder #(
    parameter int WIDTH  = 48,
    parameter int GRP    = 4,
    parameter int NSTAGE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NG  = WIDTH / GRP;
    localparam int GPS = NG / NSTAGE;
    localparam int SL  = GPS * GRP;

    logic advance;

    assign in_ready = out_ready || !out_valid;
    assign advance  = in_ready;

    // Resolves one stage slice: returns {slice carry-out, slice sum}.
    // Each group forms every internal carry as a sum of generate/propagate
    // products; groups chain carry-out into the next group's carry-in.
    function automatic logic [SL:0] cla_slice(
        input logic [SL-1:0] sa,
        input logic [SL-1:0] sb,
        input logic          sub,
        input logic          ci
    );
        logic [SL-1:0] bp, g, p;
        logic [SL:0]   cv;
        logic          c, cj, term;
        int            base;
        bp    = sub ? ~sb : sb;
        g     = sa & bp;
        p     = sa ^ bp;
        cv    = '0;
        cv[0] = ci;
        c     = ci;
        for (int grp = 0; grp < GPS; grp++) begin
            base = grp * GRP;
            for (int j = 0; j <= GRP; j++) begin
                cj = c;
                for (int i = 0; i < j; i++) cj = cj & p[base+i];
                for (int i = 0; i < j; i++) begin
                    term = g[base+i];
                    for (int m = i + 1; m < j; m++) term = term & p[base+m];
                    cj = cj | term;
                end
                cv[base+j] = cj;
            end
            c = cv[base+GRP];
        end
        return {cv[SL], p ^ cv[SL-1:0]};
    endfunction

    genvar k;
    generate
        // Intermediate stages keep resolved sum bits low and unresolved operand bits shifted down.
        for (k = 1; k < NSTAGE; k++) begin : g_pipe
            localparam int RW = WIDTH - (k - 1) * SL;
            logic [RW-1:0]    src_a, src_b;
            logic             src_valid, src_sub, src_c;
            logic [SL:0]      res;
            logic             valid_q, sub_q, c_q;
            logic [RW-SL-1:0] a_q, b_q;
            logic [k*SL-1:0]  sum_q;

            if (k == 1) begin : g_src
                assign src_a     = a;
                assign src_b     = b;
                assign src_valid = in_valid;
                assign src_sub   = op_sub;
                assign src_c     = op_sub | cin;
                always_ff @(posedge clk) begin
                    if (advance) sum_q <= res[SL-1:0];
                end
            end else begin : g_src
                assign src_a     = g_pipe[k-1].a_q;
                assign src_b     = g_pipe[k-1].b_q;
                assign src_valid = g_pipe[k-1].valid_q;
                assign src_sub   = g_pipe[k-1].sub_q;
                assign src_c     = g_pipe[k-1].c_q;
                always_ff @(posedge clk) begin
                    if (advance) sum_q <= {res[SL-1:0], g_pipe[k-1].sum_q};
                end
            end

            assign res = cla_slice(src_a[SL-1:0], src_b[SL-1:0], src_sub, src_c);

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= src_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q   <= src_a[RW-1:SL];
                    b_q   <= src_b[RW-1:SL];
                    sub_q <= src_sub;
                    c_q   <= res[SL];
                end
            end
        end
    endgenerate

    logic [SL-1:0]    f_a, f_b;
    logic             f_sub, f_c, f_valid, f_cmsb;
    logic [SL:0]      f_res;
    logic [WIDTH-1:0] f_sum;

    generate
        if (NSTAGE == 1) begin : g_last_src
            assign f_a     = a;
            assign f_b     = b;
            assign f_sub   = op_sub;
            assign f_c     = op_sub | cin;
            assign f_valid = in_valid;
            assign f_sum   = f_res[SL-1:0];
        end else begin : g_last_src
            assign f_a     = g_pipe[NSTAGE-1].a_q;
            assign f_b     = g_pipe[NSTAGE-1].b_q;
            assign f_sub   = g_pipe[NSTAGE-1].sub_q;
            assign f_c     = g_pipe[NSTAGE-1].c_q;
            assign f_valid = g_pipe[NSTAGE-1].valid_q;
            assign f_sum   = {f_res[SL-1:0], g_pipe[NSTAGE-1].sum_q};
        end
    endgenerate

    assign f_res = cla_slice(f_a, f_b, f_sub, f_c);
    // Carry into the MSB recovered from sum = a ^ b' ^ c at that bit.
    assign f_cmsb = f_sum[WIDTH-1] ^ f_a[SL-1] ^ (f_b[SL-1] ^ f_sub);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= f_valid;
            if (f_valid) begin
                sum       <= f_sum;
                carry_out <= f_res[SL];
                overflow  <= f_cmsb ^ f_res[SL];
                zero      <= (f_sum == '0);
            end
        end
    end

endmodule
